alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/reg_file4x8.sv | 37 +++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, instruction
// type codes, ALU opcodes and instruction field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    T_ALU  = 2'b00,
    T_LDI  = 2'b01,
    T_NOP  = 2'b10,
    T_HALT = 2'b11
  } itype_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DIV  = 3'd6;
  localparam logic [2:0] OP_COMP = 3'd7;

  // Field positions within the 12-bit instruction word
  localparam int TYPE_HI   = 11;
  localparam int TYPE_LO   = 10;
  localparam int OP_HI     = 9;
  localparam int OP_LO     = 7;
  localparam int RD_HI     = 6;
  localparam int RD_LO     = 5;
  localparam int RS1_HI    = 4;
  localparam int RS1_LO    = 3;
  localparam int RS2_HI    = 2;
  localparam int RS2_LO    = 1;
  localparam int LDI_RD_HI = 9;
  localparam int LDI_RD_LO = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  function automatic itype_e instr_type(input logic [11:0] ir);
    return itype_e'(ir[TYPE_HI:TYPE_LO]);
  endfunction

endpackage

// File: rtl/reg_file4x8.sv
// Four 8-bit registers with one write port, two operand read ports and a
// debug read port. Reads are combinational; reset clears all registers.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i : write port
//   raddr_a_i/rdata_a_o  : operand A read port
//   raddr_b_i/rdata_b_o  : operand B read port
//   raddr_dbg_i/rdata_dbg_o : debug read port
module reg_file4x8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [1:0] raddr_b_i,
  output logic [7:0] rdata_b_o,
  input  logic [1:0] raddr_dbg_i,
  output logic [7:0] rdata_dbg_o
);

  logic [7:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = regs_q[raddr_a_i];
  assign rdata_b_o   = regs_q[raddr_b_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an external ALU from a 12-bit program.
// Ports:
//   clk, reset, start          : clock, sync active-high reset, run pulse
//   pc, instr                  : program memory address / returned word
//   alu_a, alu_b, alu_sel      : operands and opcode to the external ALU
//   alu_out, carry_out         : ALU result and carry
//   busy, halted, carry_flag   : status
//   dbg_sel, dbg_data          : debug register read
//
// state     | meaning
// IDLE      | waiting for start, pc = 0
// FETCH     | program word for pc is on instr, latch it
// DECODE    | classify instruction, load ALU operands
// EXECUTE   | ALU operands driven, capture result
// WRITEBACK | write result to rd
// HALT      | stopped until reset
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  pc,
  input  logic [11:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        carry_out,
  output logic        busy,
  output logic        halted,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data,
  output logic        carry_flag
);

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [11:0] ir_q;
  logic [7:0]  res_q;
  logic        cout_q;
  logic        carry_q;
  logic [7:0]  alu_a_q, alu_b_q;
  logic [2:0]  alu_sel_q;

  logic [7:0]  rf_a, rf_b;
  logic [1:0]  wr_addr;
  logic        wr_en;
  itype_e      ir_type;

  assign ir_type = instr_type(ir_q);
  assign wr_addr = (ir_type == T_LDI) ? ir_q[LDI_RD_HI:LDI_RD_LO] : ir_q[RD_HI:RD_LO];
  // Reset also clears the register file, so a write in that cycle is lost.
  assign wr_en   = (state_q == S_WRITEBACK) && !reset;

  reg_file4x8 u_rf (
    .clk         (clk),
    .reset       (reset),
    .we_i        (wr_en),
    .waddr_i     (wr_addr),
    .wdata_i     (res_q),
    .raddr_a_i   (ir_q[RS1_HI:RS1_LO]),
    .rdata_a_o   (rf_a),
    .raddr_b_i   (ir_q[RS2_HI:RS2_LO]),
    .rdata_b_o   (rf_b),
    .raddr_dbg_i (dbg_sel),
    .rdata_dbg_o (dbg_data)
  );

  // The memory returns data one cycle after the address, so pc advances as
  // soon as a word is latched: during the following states it already holds
  // the next address and the word is ready when FETCH comes around again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'd0;
      ir_q      <= 12'd0;
      res_q     <= 8'd0;
      cout_q    <= 1'b0;
      carry_q   <= 1'b0;
      alu_a_q   <= 8'd0;
      alu_b_q   <= 8'd0;
      alu_sel_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          ir_q    <= instr;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (ir_type)
            T_ALU: begin
              alu_a_q   <= rf_a;
              alu_b_q   <= rf_b;
              alu_sel_q <= ir_q[OP_HI:OP_LO];
              state_q   <= S_EXECUTE;
            end
            T_LDI:   state_q <= S_EXECUTE;
            T_NOP:   state_q <= S_FETCH;
            default: state_q <= S_HALT;
          endcase
        end
        S_EXECUTE: begin
          if (ir_type == T_ALU) begin
            res_q  <= alu_out;
            cout_q <= carry_out;
          end else begin
            res_q  <= ir_q[IMM_HI:IMM_LO];
          end
          alu_a_q   <= 8'd0;
          alu_b_q   <= 8'd0;
          alu_sel_q <= 3'd0;
          state_q   <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (ir_type == T_ALU) carry_q <= cout_q;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc         = pc_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign carry_flag = carry_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pc;
  logic [11:0] instr = 12'd0;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        carry_out;
  logic        busy, halted, carry_flag;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad = 0;

  logic [11:0] rom [256];
  logic [8:0]  alu_t;
  logic [15:0] prod;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .carry_out(carry_out), .busy(busy), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  // Program memory: one cycle read latency
  always @(posedge clk) instr <= rom[pc];

  // Reference ALU
  always_comb begin
    prod  = 16'(alu_a) * 16'(alu_b);
    alu_t = 9'd0;
    case (alu_sel)
      3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_t = {1'b0, alu_a & alu_b};
      3'd3: alu_t = {1'b0, alu_a | alu_b};
      3'd4: alu_t = {1'b0, alu_a ^ alu_b};
      3'd5: alu_t = {|prod[15:8], prod[7:0]};
      3'd6: alu_t = {1'b0, (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b};
      default: alu_t = {1'b0, (alu_a < alu_b) ? 8'd1 : 8'd0};
    endcase
  end
  assign alu_out   = alu_t[7:0];
  assign carry_out = alu_t[8];

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, rd, imm};
  endfunction
  function automatic logic [11:0] aluop(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {2'b00, op, rd, rs1, rs2, 1'b0};
  endfunction
  localparam logic [11:0] NOP  = 12'h800;
  localparam logic [11:0] HALT = 12'hC00;

  task automatic fill(input logic [11:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Pulse start across one edge; returns 1 time unit after that edge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    dbg_sel = idx[1:0];
    #1 v = dbg_data;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    fill(HALT);
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (pc !== 8'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    total++; if (carry_flag !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry_flag); end
    total++; if ({alu_a, alu_b, alu_sel} !== 19'd0) begin bad++; $display("FAIL reset_alu_ops got=%h exp=0", {alu_a, alu_b, alu_sel}); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      total++; if (v !== 8'd0) begin bad++; $display("FAIL reset_R%0d got=%0d exp=0", i, v); end
    end
  endtask

  task automatic test_add_basic();
    logic [7:0] v;
    fill(HALT);
    rom[0] = ldi(2'd0, 8'd5);
    rom[1] = ldi(2'd1, 8'd3);
    rom[2] = aluop(OP_ADD, 2'd2, 2'd0, 2'd1);
    do_reset();
    pulse_start();
    cycles(10); // EXECUTE of the add
    total++; if (alu_a !== 8'd5) begin bad++; $display("FAIL add_alu_a got=%0d exp=5", alu_a); end
    total++; if (alu_b !== 8'd3) begin bad++; $display("FAIL add_alu_b got=%0d exp=3", alu_b); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", busy); end
    cycles(3);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL add_halted_early got=%b exp=0", halted); end
    cycles(1);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL add_halted_14 got=%b exp=1", halted); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_halt got=%b exp=0", busy); end
    total++; if ({alu_a, alu_b, alu_sel} !== 19'd0) begin bad++; $display("FAIL add_alu_idle got=%h exp=0", {alu_a, alu_b, alu_sel}); end
    read_reg(2, v);
    total++; if (v !== 8'd8) begin bad++; $display("FAIL add_R2 got=%0d exp=8", v); end
    read_reg(0, v);
    total++; if (v !== 8'd5) begin bad++; $display("FAIL add_R0 got=%0d exp=5", v); end
    total++; if (carry_flag !== 1'b0) begin bad++; $display("FAIL add_carry got=%b exp=0", carry_flag); end
  endtask

  task automatic test_carry();
    logic [7:0] v;
    fill(HALT);
    rom[0] = ldi(2'd0, 8'd200);
    rom[1] = ldi(2'd1, 8'd100);
    rom[2] = aluop(OP_ADD, 2'd3, 2'd0, 2'd1);
    rom[3] = ldi(2'd0, 8'd1);
    do_reset();
    pulse_start();
    cycles(12);
    total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL carry_set got=%b exp=1", carry_flag); end
    cycles(10);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL carry_halted got=%b exp=1", halted); end
    read_reg(3, v);
    total++; if (v !== 8'd44) begin bad++; $display("FAIL carry_R3 got=%0d exp=44", v); end
    read_reg(0, v);
    total++; if (v !== 8'd1) begin bad++; $display("FAIL carry_ldi_R0 got=%0d exp=1", v); end
    total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL carry_kept_by_ldi got=%b exp=1", carry_flag); end
  endtask

  task automatic test_hazard();
    logic [7:0] v;
    fill(HALT);
    rom[0] = ldi(2'd0, 8'd5);
    rom[1] = aluop(OP_SUB, 2'd0, 2'd0, 2'd0);
    rom[2] = ldi(2'd1, 8'd7);
    rom[3] = aluop(OP_ADD, 2'd1, 2'd1, 2'd1);
    rom[4] = aluop(OP_ADD, 2'd2, 2'd1, 2'd0);
    do_reset();
    pulse_start();
    cycles(6); // EXECUTE of the sub
    total++; if (alu_sel !== OP_SUB) begin bad++; $display("FAIL hz_sel got=%0d exp=1", alu_sel); end
    total++; if ({alu_a, alu_b} !== {8'd5, 8'd5}) begin bad++; $display("FAIL hz_ops got=%h exp=0505", {alu_a, alu_b}); end
    cycles(24);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL hz_halted got=%b exp=1", halted); end
    read_reg(0, v);
    total++; if (v !== 8'd0) begin bad++; $display("FAIL hz_R0 got=%0d exp=0", v); end
    read_reg(1, v);
    total++; if (v !== 8'd14) begin bad++; $display("FAIL hz_R1 got=%0d exp=14", v); end
    read_reg(2, v);
    total++; if (v !== 8'd14) begin bad++; $display("FAIL hz_R2 got=%0d exp=14", v); end
  endtask

  task automatic test_div_zero();
    logic [7:0] v;
    fill(HALT);
    rom[0] = ldi(2'd0, 8'd9);
    rom[1] = ldi(2'd1, 8'd0);
    rom[2] = aluop(OP_DIV, 2'd2, 2'd0, 2'd1);
    do_reset();
    pulse_start();
    cycles(20);
    read_reg(2, v);
    total++; if (v !== 8'hFF) begin bad++; $display("FAIL div0_R2 got=%0h exp=ff", v); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL div0_halted got=%b exp=1", halted); end
  endtask

  task automatic test_nop_latency();
    fill(HALT);
    rom[0] = NOP;
    do_reset();
    pulse_start();
    cycles(2); // FETCH of word 1
    total++; if (pc !== 8'd1) begin bad++; $display("FAIL nop_pc got=%0d exp=1", pc); end
    cycles(1);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL nop_halted_early got=%b exp=0", halted); end
    cycles(1);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL nop_halted got=%b exp=1", halted); end
  endtask

  task automatic test_pc_wrap();
    logic saw_top, wrapped;
    saw_top = 1'b0;
    wrapped = 1'b0;
    fill(NOP);
    do_reset();
    pulse_start();
    for (int i = 0; i < 600; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy cycle=%0d got=%b exp=1", i, busy); end
      if (pc == 8'd255) saw_top = 1'b1;
      if (saw_top && pc == 8'd0) wrapped = 1'b1;
      cycles(1);
    end
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap_pc got=%b exp=1 (pc=%0d)", wrapped, pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL wrap_halted got=%b exp=0", halted); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] v;
    fill(HALT);
    rom[0] = ldi(2'd0, 8'd5);
    rom[1] = ldi(2'd1, 8'd3);
    do_reset();
    pulse_start();
    cycles(5); // DECODE of the second LDI, pc already 2
    pulse_start();
    total++; if (pc !== 8'd2) begin bad++; $display("FAIL ign_busy_pc got=%0d exp=2", pc); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
    cycles(10);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL ign_halted got=%b exp=1", halted); end
    pulse_start();
    cycles(2);
    total++; if (pc !== 8'd3) begin bad++; $display("FAIL ign_halt_pc got=%0d exp=3", pc); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL ign_stay_halted got=%b exp=1", halted); end
    read_reg(1, v);
    total++; if (v !== 8'd3) begin bad++; $display("FAIL ign_R1_retained got=%0d exp=3", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    fill(HALT);
    rom[0] = ldi(2'd1, 8'd9);
    do_reset();
    pulse_start();
    cycles(3); // WRITEBACK of the LDI
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_wb got=%b exp=1", busy); end
    reset = 1'b1;
    start = 1'b1;
    cycles(1);
    reset = 1'b0;
    start = 1'b0;
    total++; if ({busy, halted} !== 2'b00) begin bad++; $display("FAIL mid_idle got=%b exp=00", {busy, halted}); end
    total++; if (pc !== 8'd0) begin bad++; $display("FAIL mid_pc got=%0d exp=0", pc); end
    read_reg(1, v);
    total++; if (v !== 8'd0) begin bad++; $display("FAIL mid_R1 got=%0d exp=0", v); end
    cycles(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_stay_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry();
    test_hazard();
    test_div_zero();
    test_nop_latency();
    test_pc_wrap();
    test_start_ignored();
    test_reset_mid();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
